// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll tracker: FSM state encoding
// and the legal face range.
package dice_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROLL,
    WAIT,
    CAPTURE,
    DONE
  } dice_trk_state_t;

  localparam logic [2:0] FACE_MIN  = 3'd1;
  localparam logic [2:0] FACE_MAX  = 3'd6;
  localparam int         NUM_FACES = 6;

  function automatic logic face_is_valid(input logic [2:0] v);
    return (v >= FACE_MIN) && (v <= FACE_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_tracker_if.sv
// Host and generator signals of the dice roll tracker bundled as one interface.
// Optional roll_sum is present only when DICE_SUM_EN is defined.
interface dice_roll_tracker_if #(
  parameter int CNT_W = 8,
  parameter int N_W   = 8
);
  logic             start;
  logic [N_W-1:0]   num_rolls;
  logic             roll;
  logic [2:0]       dice_value;
  logic             busy;
  logic             done;
  logic [2:0]       rd_face;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] invalid_cnt;
`ifdef DICE_SUM_EN
  logic [N_W+2:0]   roll_sum;

  modport master (
    output start, num_rolls, dice_value, rd_face,
    input  roll, busy, done, rd_count, invalid_cnt, roll_sum
  );
  modport slave (
    input  start, num_rolls, dice_value, rd_face,
    output roll, busy, done, rd_count, invalid_cnt, roll_sum
  );
`else
  modport master (
    output start, num_rolls, dice_value, rd_face,
    input  roll, busy, done, rd_count, invalid_cnt
  );
  modport slave (
    input  start, num_rolls, dice_value, rd_face,
    output roll, busy, done, rd_count, invalid_cnt
  );
`endif
endinterface

// File: rtl/dice_face_counter.sv
// Saturating up-counter with synchronous clear; one instance per face plus
// one for invalid captures.
module dice_face_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dice_roll_tracker.sv
// Issues a batch of roll pulses to a dice generator and keeps a saturating
// per-face histogram. Optional DICE_SUM_EN adds a running sum of valid faces.
module dice_roll_tracker
  import dice_pkg::*;
#(
  parameter int RESP_LAT = 1,
  parameter int CNT_W    = 8,
  parameter int N_W      = 8
) (
  input logic          clk,
  input logic          reset,
  dice_roll_tracker_if.slave bus
);

  dice_trk_state_t state_reg, state_next;
  logic [N_W-1:0]  remaining_reg, remaining_next;
  logic [3:0]      wait_reg, wait_next;
  logic            roll_next;
  logic            done_next;

  logic accept;
  logic capture;
  logic face_valid;

  assign accept     = (state_reg == IDLE) && bus.start;
  assign capture    = (state_reg == CAPTURE);
  assign face_valid = face_is_valid(bus.dice_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      wait_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      wait_reg      <= wait_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    wait_next      = wait_reg;
    roll_next      = 1'b0;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          remaining_next = bus.num_rolls;
          state_next     = (bus.num_rolls == '0) ? DONE : ROLL;
        end
      end
      ROLL: begin
        roll_next  = 1'b1;
        // WAIT lasts RESP_LAT cycles, counting down to zero.
        wait_next  = 4'(RESP_LAT - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_reg == '0) begin
          state_next = CAPTURE;
        end else begin
          wait_next = wait_reg - 4'd1;
        end
      end
      CAPTURE: begin
        remaining_next = remaining_reg - N_W'(1);
        state_next     = (remaining_reg == N_W'(1)) ? DONE : ROLL;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.roll = roll_next;
  assign bus.done = done_next;
  assign bus.busy = (state_reg != IDLE);

  // Index 0 holds the invalid count; indices 1..6 are the faces.
  logic [CNT_W-1:0]   cnt [0:NUM_FACES];
  logic [NUM_FACES:0] inc;

  generate
    for (genvar gi = 0; gi <= NUM_FACES; gi++) begin : g_cnt
      if (gi == 0) begin : g_invalid
        assign inc[gi] = capture && !face_valid;
      end else begin : g_face
        assign inc[gi] = capture && (bus.dice_value == 3'(gi));
      end

      dice_face_counter #(
        .CNT_W (CNT_W)
      ) u_counter (
        .clk   (clk),
        .srst  (reset),
        .clr   (accept),
        .inc   (inc[gi]),
        .count (cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.rd_count = '0;
    if (face_is_valid(bus.rd_face)) begin
      bus.rd_count = cnt[bus.rd_face];
    end
  end

  assign bus.invalid_cnt = cnt[0];

`ifdef DICE_SUM_EN
  logic [N_W+2:0] sum_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
    end else if (accept) begin
      sum_reg <= '0;
    end else if (capture && face_valid) begin
      sum_reg <= sum_reg + (N_W + 3)'(bus.dice_value);
    end
  end

  assign bus.roll_sum = sum_reg;
`endif

endmodule

// File: tb/tb_dice_roll_tracker.sv
// Scoreboard bench for dice_roll_tracker: two instances (RESP_LAT=1/CNT_W=8
// and RESP_LAT=4/CNT_W=4), a generator model per instance, checks on done.
module tb_dice_roll_tracker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst0, rst1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dice_roll_tracker_if #(.CNT_W(8), .N_W(8)) if0 ();
  dice_roll_tracker_if #(.CNT_W(4), .N_W(8)) if1 ();

  dice_roll_tracker #(.RESP_LAT(1), .CNT_W(8), .N_W(8)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (if0.slave)
  );

  dice_roll_tracker #(.RESP_LAT(4), .CNT_W(4), .N_W(8)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (if1.slave)
  );

  typedef struct {
    int rolls;
    int done_cyc;
    int cnt[7];
    int sum;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   face_q0[$];
  int   face_q1[$];
  exp_t e0, e1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Generator models: a new face appears one step after each roll pulse and holds.
  always @(posedge clk) begin
    if (if0.roll) begin
      #1;
      if0.dice_value = (face_q0.size() > 0) ? 3'(face_q0.pop_front()) : 3'd6;
    end
  end

  always @(posedge clk) begin
    if (if1.roll) begin
      #1;
      if1.dice_value = (face_q1.size() > 0) ? 3'(face_q1.pop_front()) : 3'd6;
    end
  end

  int rolls0 = 0, last0 = 0, rolls1 = 0, last1 = 0;

  always @(negedge clk) begin
    if (rst0) begin
      rolls0 = 0;
    end else begin
      if (if0.roll) begin
        if (rolls0 > 0) chk("dut0 roll spacing", cyc - last0, 3);
        last0 = cyc;
        rolls0++;
      end
      if (if0.done) begin
        if (q0.size() == 0) begin
          chk("dut0 unexpected done", 1, 0);
        end else begin
          e0 = q0.pop_front();
          chk("dut0 done cycle", cyc, e0.done_cyc);
          chk("dut0 roll count", rolls0, e0.rolls);
          for (int f = 1; f <= 6; f++) begin
            if0.rd_face = 3'(f);
            #1;
            chk($sformatf("dut0 face%0d count", f), int'(if0.rd_count), e0.cnt[f]);
          end
          if0.rd_face = 3'd7;
          #1;
          chk("dut0 rd_face 7", int'(if0.rd_count), 0);
          chk("dut0 invalid_cnt", int'(if0.invalid_cnt), e0.cnt[0]);
`ifdef DICE_SUM_EN
          chk("dut0 roll_sum", int'(if0.roll_sum), e0.sum);
`endif
        end
        rolls0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst1) begin
      rolls1 = 0;
    end else begin
      if (if1.roll) begin
        if (rolls1 > 0) chk("dut1 roll spacing", cyc - last1, 6);
        last1 = cyc;
        rolls1++;
      end
      if (if1.done) begin
        if (q1.size() == 0) begin
          chk("dut1 unexpected done", 1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("dut1 done cycle", cyc, e1.done_cyc);
          chk("dut1 roll count", rolls1, e1.rolls);
          for (int f = 1; f <= 6; f++) begin
            if1.rd_face = 3'(f);
            #1;
            chk($sformatf("dut1 face%0d count", f), int'(if1.rd_count), e1.cnt[f]);
          end
          chk("dut1 invalid_cnt", int'(if1.invalid_cnt), e1.cnt[0]);
`ifdef DICE_SUM_EN
          chk("dut1 roll_sum", int'(if1.roll_sum), e1.sum);
`endif
        end
        rolls1 = 0;
      end
    end
  end

  // Issue one batch; when want_done is set, the expected result is queued.
  task automatic batch(input int d, input int n, input int vals[$], input bit want_done);
    exp_t e;
    int   cap;
    int   per;
    cap = (d == 0) ? 255 : 15;
    per = (d == 0) ? 3 : 6;
    e.rolls = n;
    e.sum   = 0;
    for (int i = 0; i < 7; i++) e.cnt[i] = 0;
    for (int i = 0; i < n; i++) begin
      if (vals[i] >= 1 && vals[i] <= 6) begin
        if (e.cnt[vals[i]] < cap) e.cnt[vals[i]]++;
        e.sum += vals[i];
      end else if (e.cnt[0] < cap) begin
        e.cnt[0]++;
      end
      if (d == 0) face_q0.push_back(vals[i]);
      else        face_q1.push_back(vals[i]);
    end
    @(negedge clk);
    e.done_cyc = cyc + 1 + n * per;
    if (d == 0) begin
      if0.start = 1'b1;
      if0.num_rolls = 8'(n);
      if (want_done) q0.push_back(e);
    end else begin
      if1.start = 1'b1;
      if1.num_rolls = 8'(n);
      if (want_done) q1.push_back(e);
    end
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((d == 0) ? if0.busy : if1.busy) && k < budget);
    if (k >= budget) chk($sformatf("dut%0d idle timeout", d), 1, 0);
  endtask

  initial begin
    if0.start = 1'b0;  if0.num_rolls = '0;
    if1.start = 1'b0;  if1.num_rolls = '0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("reset roll", int'(if0.roll), 0);
    chk("reset busy", int'(if0.busy), 0);
    chk("reset done", int'(if0.done), 0);
    chk("reset invalid_cnt", int'(if0.invalid_cnt), 0);
    chk("reset rd_count", int'(if0.rd_count), 0);
    chk("reset dut1 busy", int'(if1.busy), 0);

    batch(0, 10, '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4}, 1'b1);
    wait_idle(0, 100);

    batch(0, 4, '{0, 7, 3, 7}, 1'b1);
    wait_idle(0, 50);

    batch(0, 0, '{0}, 1'b1);
    @(negedge clk);
    chk("zero rolls busy in done", int'(if0.busy), 1);
    wait_idle(0, 10);

    // A second start mid-batch must be ignored.
    batch(0, 5, '{6, 5, 4, 3, 2}, 1'b1);
    repeat (4) @(negedge clk);
    if0.start = 1'b1;
    if0.num_rolls = 8'd9;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    wait_idle(0, 50);
    repeat (3) @(negedge clk);

    // Reset during WAIT of roll 3 (cycle 8 after acceptance).
    batch(0, 5, '{0, 7, 1, 1, 1}, 1'b0);
    repeat (8) @(negedge clk);
    chk("pre-reset busy", int'(if0.busy), 1);
    chk("pre-reset invalid_cnt", int'(if0.invalid_cnt), 2);
    #1;
    rst0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid reset busy", int'(if0.busy), 0);
    chk("mid reset roll", int'(if0.roll), 0);
    chk("mid reset done", int'(if0.done), 0);
    chk("mid reset invalid_cnt", int'(if0.invalid_cnt), 0);
    #1;
    rst0 = 1'b0;
    face_q0.delete();
    repeat (20) @(negedge clk);

    batch(1, 20, '{6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6}, 1'b1);
    wait_idle(1, 200);
    batch(1, 3, '{7, 2, 2}, 1'b1);
    wait_idle(1, 50);

    repeat (5) @(negedge clk);
    chk("dut0 scoreboard drained", q0.size(), 0);
    chk("dut1 scoreboard drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
